pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register chain.
//
// Carries a DATA_W-bit payload through DEPTH register stages. Stage 0 faces
// the producer and stage DEPTH-1 faces the consumer. Each stage has its own
// valid bit. Features:
//   - valid/ready backpressure with bubble collapsing (an empty stage always
//     accepts from its predecessor, even while later stages are stalled)
//   - hold_i: global stall that freezes every stage and blocks both sides
//   - flush_i: squashes every in-flight entry at the next edge
//   - count_o: registered number of occupied stages
//
// Optional build macro PIPE_STAGE_PERF_EN adds a 16-bit saturating counter
// (stall_cnt_o). It counts edges where the output stage holds valid data but
// cannot hand it off (out_ready_i low or hold_i high). Only reset clears it.
//
// Priority of control: reset > flush > hold > normal flow.
// The reset is synchronous and active-low. All state updates on the rising
// edge of clk_i.

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  valid_next;
    logic [DATA_W-1:0] data_reg  [DEPTH];
    logic [DATA_W-1:0] data_next [DEPTH];
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    // Values each stage would load if it advances: the chain input for
    // stage 0, the predecessor stage for all others.
    logic [DEPTH-1:0]  stage_in_valid;
    logic [DATA_W-1:0] stage_in_data [DEPTH];

    // adv[k] = stage k loads this edge. adv[DEPTH] = consumer takes the
    // output stage. The chain of ORs is what collapses bubbles: a stage
    // that is empty advances regardless of what is downstream.
    logic [DEPTH:0] adv;

    // Flush is deliberately absent from the output-side term. It does not
    // matter for state, because flush clears every valid bit. The visible
    // handshake is already masked through out_valid_o.
    assign adv[DEPTH] = out_ready_i & ~hold_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign adv[gi] = (~valid_reg[gi] | adv[gi+1]) & ~hold_i & ~flush_i;

            if (gi == 0) begin : g_head
                assign stage_in_valid[gi] = in_valid_i;
                assign stage_in_data[gi]  = in_data_i;
            end else begin : g_body
                assign stage_in_valid[gi] = valid_reg[gi-1];
                assign stage_in_data[gi]  = data_reg[gi-1];
            end

            // Flush wins over advance for the valid bit. Data only moves on
            // advance, so invalid entries may keep stale payload.
            assign valid_next[gi] = flush_i ? 1'b0 :
                                    adv[gi] ? stage_in_valid[gi] :
                                              valid_reg[gi];
            assign data_next[gi]  = adv[gi] ? stage_in_data[gi] : data_reg[gi];
        end
    endgenerate

    // Occupancy of the next state, so count_o changes on the same edge as
    // the valid bits.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CNT_W'(valid_next[i]);
        end
    end

    // Stage registers and occupancy counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= data_next[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o  = adv[0];
    assign out_valid_o = valid_reg[DEPTH-1] & ~hold_i & ~flush_i;
    assign out_data_o  = data_reg[DEPTH-1];
    assign count_o     = count_reg;

`ifdef PIPE_STAGE_PERF_EN
    // ------------------------------------------------------------------
    // Output stall counter
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt_reg;
    logic [15:0] stall_cnt_next;
    logic        stall_event;

    // The output stage is loaded but the consumer side is blocked.
    assign stall_event = valid_reg[DEPTH-1] & (~out_ready_i | hold_i);

    // Saturating increment. Flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_event && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. Four instances (DEPTH 1..4, DATA_W=8) share
// one stimulus. A scoreboard on the DEPTH=3 instance checks delivery order.
// Directed checks cover latency, backpressure, collapsing, hold, flush, reset
// and, with PIPE_STAGE_PERF_EN, the stall counter.
module tb_pipe_stage_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       hold;
    logic       flush;

    logic       rdy1, ov1, rdy2, ov2, rdy3, ov3, rdy4, ov4;
    logic [7:0] od1, od2, od3, od4;
    logic [0:0] cnt1;
    logic [1:0] cnt2;
    logic [1:0] cnt3;
    logic [2:0] cnt4;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] sc1, sc2, sc3, sc4;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .DEPTH(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready),
        .out_data_o(od1), .hold_i(hold), .flush_i(flush), .count_o(cnt1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc1)
`endif
    );
    pipe_stage_reg #(.DATA_W(8), .DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .in_data_i(in_data), .out_valid_o(ov2), .out_ready_i(out_ready),
        .out_data_o(od2), .hold_i(hold), .flush_i(flush), .count_o(cnt2)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc2)
`endif
    );
    pipe_stage_reg #(.DATA_W(8), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy3),
        .in_data_i(in_data), .out_valid_o(ov3), .out_ready_i(out_ready),
        .out_data_o(od3), .hold_i(hold), .flush_i(flush), .count_o(cnt3)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc3)
`endif
    );
    pipe_stage_reg #(.DATA_W(8), .DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .in_data_i(in_data), .out_valid_o(ov4), .out_ready_i(out_ready),
        .out_data_o(od4), .hold_i(hold), .flush_i(flush), .count_o(cnt4)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and stay stable until the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard on the DEPTH=3 instance. At the falling edge the inputs and
    // outputs are exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (ov3 && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    check("sb_data", 32'(od3), 32'(sb_q[0]));
                    $display("xfer d3 out data=0x%02h", od3);
                    void'(sb_q.pop_front());
                end
            end
            if (in_valid && rdy3) begin
                sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        step(); step();
        // Reset state
        check("rst_ov3", 32'(ov3), 32'd0);
        check("rst_od3", 32'(od3), 32'd0);
        check("rst_cnt3", 32'(cnt3), 32'd0);
        check("rst_rdy3", 32'(rdy3), 32'd1);
        check("rst_od4", 32'(od4), 32'd0);
        rst_n = 1'b1;

        // Streaming through DEPTH=3 with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        step();
        check("s1_ov", 32'(ov3), 32'd0);
        check("s1_cnt", 32'(cnt3), 32'd1);
        in_data = 8'h22; step();
        check("s2_ov", 32'(ov3), 32'd0);
        in_data = 8'h33; step();
        check("s3_ov", 32'(ov3), 32'd1);
        check("s3_od", 32'(od3), 32'h11);
        check("s3_cnt", 32'(cnt3), 32'd3);
        in_valid = 1'b0; step();
        check("s4_od", 32'(od3), 32'h22);
        check("s4_cnt", 32'(cnt3), 32'd2);
        step();
        check("s5_od", 32'(od3), 32'h33);
        step();
        check("s6_ov", 32'(ov3), 32'd0);
        check("s6_cnt", 32'(cnt3), 32'd0);

        // Backpressure: fill DEPTH=3 with out_ready low
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; step();
        in_data = 8'hA2; step();
        in_data = 8'hA3; step();
        in_data = 8'hA4;
        check("bp_rdy", 32'(rdy3), 32'd0);
        check("bp_cnt", 32'(cnt3), 32'd3);
        check("bp_od", 32'(od3), 32'hA1);
        step();
        check("bp_cnt_held", 32'(cnt3), 32'd3);
        out_ready = 1'b1; #1;
        check("bp_rdy_comb", 32'(rdy3), 32'd1);
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        check("bp_after_od", 32'(od3), 32'hA2);
        check("bp_after_cnt", 32'(cnt3), 32'd3);
        out_ready = 1'b1;
        step(); step(); step();
        check("bp_drained", 32'(cnt3), 32'd0);

        // Bubble collapsing in DEPTH=4
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h02; step();
        in_valid = 1'b0; step(); step(); step();
        check("bc_cnt4", 32'(cnt4), 32'd2);
        check("bc_ov4", 32'(ov4), 32'd1);
        check("bc_od4", 32'(od4), 32'h01);
        out_ready = 1'b1; step();
        check("bc_od4_next", 32'(od4), 32'h02);
        step(); step(); step(); step();

        // Hold on DEPTH=2
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h5B; step();
        in_data = 8'h5A; step();
        hold = 1'b1; out_ready = 1'b1; in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ov2", 32'(ov2), 32'd0);
            check("hold_rdy2", 32'(rdy2), 32'd0);
            step();
            check("hold_cnt2", 32'(cnt2), 32'd2);
        end
        hold = 1'b0; in_valid = 1'b0; #1;
        check("hold_rel_ov2", 32'(ov2), 32'd1);
        check("hold_rel_od2", 32'(od2), 32'h5B);
        step();
        check("hold_rel_od2b", 32'(od2), 32'h5A);
        step(); step(); step();

        // Flush on full DEPTH=3, then mid-stream reset
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hC1; step();
        in_data = 8'hC2; step();
        in_data = 8'hC3; step();
        check("fl_full", 32'(cnt3), 32'd3);
        flush = 1'b1; out_ready = 1'b1; in_data = 8'hFF; #1;
        check("fl_rdy", 32'(rdy3), 32'd0);
        check("fl_ov", 32'(ov3), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_cnt", 32'(cnt3), 32'd0);
        check("fl_ov_next", 32'(ov3), 32'd0);
        in_valid = 1'b1; in_data = 8'hD1; step();
        in_data = 8'hD2; step();
        in_valid = 1'b0;
        check("ms_cnt", 32'(cnt3), 32'd2);
        rst_n = 1'b0; step();
        check("ms_rst_cnt", 32'(cnt3), 32'd0);
        check("ms_rst_od", 32'(od3), 32'd0);
        check("ms_rst_ov", 32'(ov3), 32'd0);
        rst_n = 1'b1; step(); step();
        check("ms_quiet_ov", 32'(ov3), 32'd0);

        // DEPTH=1 latency and stall counter
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE1; step();
        in_valid = 1'b0;
        check("d1_ov", 32'(ov1), 32'd1);
        check("d1_od", 32'(od1), 32'hE1);
        check("d1_cnt", 32'(cnt1), 32'd1);
`ifdef PIPE_STAGE_PERF_EN
        repeat (5) step();
        check("perf_5", 32'(sc1), 32'd5);
        repeat (65534 - 5) step();
        check("perf_fffe", 32'(sc1), 32'hFFFE);
        repeat (4) step();
        check("perf_sat", 32'(sc1), 32'hFFFF);
        flush = 1'b1; step(); flush = 1'b0;
        check("perf_flush_keep", 32'(sc1), 32'hFFFF);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("perf_rst", 32'(sc1), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
